// File: rtl/mapper_mmc1.sv
`default_nettype none
// ============================================================================
// mapper_mmc1 : MMC1 (SxROM) serial-register bank mapper for the cart bus.
// Optional PRG RAM select enabled by defining MMC1_PRG_RAM_EN.  Rev 1.0
// ============================================================================
module mapper_mmc1 #(
  parameter int PRG_BANKS_W = 4,
  parameter int CHR_BANKS_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m2,
  input  logic [14:0]              cpu_addr,
  input  logic [7:0]               cpu_data_i,
  input  logic                     cpu_rw,
  input  logic                     romsel,
  input  logic [13:0]              ppu_addr,
  output logic [PRG_BANKS_W+13:0]  prg_addr,
  output logic [CHR_BANKS_W+11:0]  chr_addr,
  output logic                     prg_ram_cs,
  output logic                     ciram_ce,
  output logic                     ciram_a10,
  output logic                     irq
);

  localparam logic [4:0] C_CTRL_RESET = 5'b01100;

  logic       wr_q,      wr_d;
  logic [4:0] shift_q,   shift_d;
  logic [2:0] count_q,   count_d;
  logic [4:0] control_q, control_d;
  logic [4:0] chr0_q,    chr0_d;
  logic [4:0] chr1_q,    chr1_d;
  logic [4:0] prg_q,     prg_d;

  logic       w_accept;
  logic [4:0] w_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q      <= 1'b0;
      shift_q   <= 5'b00000;
      count_q   <= 3'd0;
      control_q <= C_CTRL_RESET;
      chr0_q    <= 5'b00000;
      chr1_q    <= 5'b00000;
      prg_q     <= 5'b00000;
    end else begin
      wr_q      <= wr_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  // Only the first cycle of a write burst counts, so the dummy write of a
  // read-modify-write instruction does not shift in a second bit.
  always_comb begin
    wr_d      = romsel & ~cpu_rw;
    w_accept  = wr_d & ~wr_q;
    w_value   = {cpu_data_i[0], shift_q[4:1]};
    shift_d   = shift_q;
    count_d   = count_q;
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    if (w_accept) begin
      if (cpu_data_i[7]) begin
        shift_d   = 5'b00000;
        count_d   = 3'd0;
        control_d = control_q | C_CTRL_RESET;
      end else if (count_q != 3'd4) begin
        shift_d = w_value;
        count_d = count_q + 3'd1;
      end else begin
        shift_d = 5'b00000;
        count_d = 3'd0;
        case (cpu_addr[14:13])
          2'd0:    control_d = w_value;
          2'd1:    chr0_d    = w_value;
          2'd2:    chr1_d    = w_value;
          default: prg_d     = w_value;
        endcase
      end
    end
  end

  // Zero-extend the raw bank registers, then keep the parameterised width.
  logic [31:0]            w_prg_ext;
  logic [31:0]            w_chr0_ext;
  logic [31:0]            w_chr1_ext;
  logic [PRG_BANKS_W-1:0] w_prg_b;
  logic [PRG_BANKS_W-1:0] w_prg_bank;
  logic [CHR_BANKS_W-1:0] w_chr0_b;
  logic [CHR_BANKS_W-1:0] w_chr1_b;
  logic [CHR_BANKS_W-1:0] w_chr_bank;

  assign w_prg_ext  = {28'd0, prg_q[3:0]};
  assign w_chr0_ext = {27'd0, chr0_q};
  assign w_chr1_ext = {27'd0, chr1_q};
  assign w_prg_b    = w_prg_ext[PRG_BANKS_W-1:0];
  assign w_chr0_b   = w_chr0_ext[CHR_BANKS_W-1:0];
  assign w_chr1_b   = w_chr1_ext[CHR_BANKS_W-1:0];

  always_comb begin
    w_prg_bank = w_prg_b;
    case (control_q[3:2])
      2'd2:    w_prg_bank = cpu_addr[14] ? w_prg_b : '0;
      2'd3:    w_prg_bank = cpu_addr[14] ? '1 : w_prg_b;
      default: w_prg_bank = (w_prg_b & ~PRG_BANKS_W'(1)) | PRG_BANKS_W'(cpu_addr[14]);
    endcase
  end

  always_comb begin
    if (control_q[4]) begin
      w_chr_bank = ppu_addr[12] ? w_chr1_b : w_chr0_b;
    end else begin
      w_chr_bank = (w_chr0_b & ~CHR_BANKS_W'(1)) | CHR_BANKS_W'(ppu_addr[12]);
    end
  end

  always_comb begin
    case (control_q[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_addr[10];
      default: ciram_a10 = ppu_addr[11];
    endcase
  end

  assign prg_addr = {w_prg_bank, cpu_addr[13:0]};
  assign chr_addr = {w_chr_bank, ppu_addr[11:0]};
  assign ciram_ce = ppu_addr[13];
  assign irq      = 1'b0;

`ifdef MMC1_PRG_RAM_EN
  assign prg_ram_cs = m2 & ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg_q[4];
`else
  assign prg_ram_cs = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{m2, prg_q[4], cpu_data_i[6:1], w_prg_ext, w_chr0_ext, w_chr1_ext};

endmodule
`default_nettype wire
